// File: rtl/bcd_display_scan_if.sv
// rtl/bcd_display_scan_if.sv - load/value inputs and multiplexed display outputs of the BCD scanner
interface bcd_display_scan_if;
    logic        load;
    logic [15:0] bcd_in;
    logic        blank_lz;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        err;

    modport master (
        output load, bcd_in, blank_lz,
        input  an, seg, err
    );

    modport slave (
        input  load, bcd_in, blank_lz,
        output an, seg, err
    );
endinterface

// File: rtl/bcd_display_scan.sv
// rtl/bcd_display_scan.sv - four-digit BCD hold register with time-multiplexed 7-segment scan
// Outputs are registered from the current pcnt/dig/val, so they trail the prescaler by one cycle.
module bcd_display_scan #(
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 500
) (
    input logic              clk,
    input logic              rst,
    bcd_display_scan_if.slave bus
);
    localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

    logic [PW-1:0] pcnt;
    logic [1:0]    dig;
    logic [15:0]   val;
    logic          err_q;
    logic [3:0]    an_q;
    logic [6:0]    seg_q;

    logic [3:0]    an_d;
    logic [6:0]    seg_d;
    logic [3:0]    cur_nib;
    logic [3:0]    hi_zero;
    logic          pwrap;

    function automatic logic [6:0] decode(input logic [3:0] n);
        case (n)
            4'd0:    decode = 7'b1000000;
            4'd1:    decode = 7'b1111001;
            4'd2:    decode = 7'b0100100;
            4'd3:    decode = 7'b0110000;
            4'd4:    decode = 7'b0011001;
            4'd5:    decode = 7'b0010010;
            4'd6:    decode = 7'b0000010;
            4'd7:    decode = 7'b1111000;
            4'd8:    decode = 7'b0000000;
            4'd9:    decode = 7'b0010000;
            default: decode = 7'b0111111;
        endcase
    endfunction

    function automatic logic any_bad(input logic [15:0] v);
        any_bad = (v[3:0] > 4'd9) || (v[7:4] > 4'd9) || (v[11:8] > 4'd9) || (v[15:12] > 4'd9);
    endfunction

    assign pwrap = (pcnt == PW'(SCAN_DIV - 1));

    always_comb begin
        cur_nib    = val[{dig, 2'b00} +: 4];
        // hi_zero[i]: nibble i and everything above it are zero; digit 0 is never suppressed
        hi_zero[3] = (val[15:12] == 4'd0);
        hi_zero[2] = hi_zero[3] && (val[11:8] == 4'd0);
        hi_zero[1] = hi_zero[2] && (val[7:4] == 4'd0);
        hi_zero[0] = 1'b0;
        an_d       = 4'b1111;
        seg_d      = 7'b1111111;
        if (int'(pcnt) >= BLANK_CYC && !(bus.blank_lz && hi_zero[dig])) begin
            an_d        = 4'b1111;
            an_d[dig]   = 1'b0;
            seg_d       = decode(cur_nib);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt  <= '0;
            dig   <= 2'd0;
            val   <= 16'h0000;
            err_q <= 1'b0;
            an_q  <= 4'b1111;
            seg_q <= 7'b1111111;
        end else begin
            pcnt  <= pwrap ? '0 : pcnt + 1'b1;
            if (pwrap) begin
                dig <= dig + 2'd1;
            end
            if (bus.load) begin
                val   <= bus.bcd_in;
                err_q <= any_bad(bus.bcd_in);
            end
            an_q  <= an_d;
            seg_q <= seg_d;
        end
    end

    assign bus.an  = an_q;
    assign bus.seg = seg_q;
    assign bus.err = err_q;
endmodule

// File: tb/tb_bcd_display_scan.sv
// tb/tb_bcd_display_scan.sv - cycle model check plus directed literal checks for bcd_display_scan
module tb_bcd_display_scan;
    localparam int SD = 4;
    localparam int BC = 1;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    int          m_cnt;
    logic [15:0] m_val;
    logic        m_err;
    logic        m_valid;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_err;

    bcd_display_scan_if bus ();

    bcd_display_scan #(.SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] ref_seg(input int n);
        case (n)
            0: ref_seg = 7'b1000000;
            1: ref_seg = 7'b1111001;
            2: ref_seg = 7'b0100100;
            3: ref_seg = 7'b0110000;
            4: ref_seg = 7'b0011001;
            5: ref_seg = 7'b0010010;
            6: ref_seg = 7'b0000010;
            7: ref_seg = 7'b1111000;
            8: ref_seg = 7'b0000000;
            9: ref_seg = 7'b0010000;
            default: ref_seg = 7'b0111111;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // One clock: model consumes the pre-edge state, outputs are checked on the falling edge.
    task automatic tick();
        int p;
        int d;
        int nib;
        @(posedge clk);
        if (rst) begin
            e_an    = 4'b1111;
            e_seg   = 7'b1111111;
            m_val   = 16'h0000;
            m_err   = 1'b0;
            m_cnt   = 0;
            m_valid = 1'b1;
        end else begin
            p     = m_cnt % SD;
            d     = (m_cnt / SD) % 4;
            nib   = int'((m_val >> (4 * d)) & 16'hF);
            e_an  = 4'b1111;
            e_seg = 7'b1111111;
            if (p >= BC && !(bus.blank_lz && d > 0 && (m_val >> (4 * d)) == 16'h0)) begin
                e_an  = ~(4'b0001 << d);
                e_seg = ref_seg(nib);
            end
            if (bus.load) begin
                m_val = bus.bcd_in;
                m_err = 1'b0;
                for (int k = 0; k < 4; k++)
                    if (((bus.bcd_in >> (4 * k)) & 16'hF) > 16'd9) m_err = 1'b1;
            end
            m_cnt++;
        end
        e_err = m_err;
        @(negedge clk);
        if (m_valid) begin
            chk("model_an", {12'h0, bus.an}, {12'h0, e_an});
            chk("model_seg", {9'h0, bus.seg}, {9'h0, e_seg});
            chk("model_err", {15'h0, bus.err}, {15'h0, e_err});
            chk("one_hot_an", 16'($countones(~bus.an) <= 1), 16'h1);
        end
    endtask

    task automatic do_load(input logic [15:0] v);
        bus.load   = 1'b1;
        bus.bcd_in = v;
        tick();
        bus.load   = 1'b0;
    endtask

    task automatic wait_an(input logic [3:0] a, input logic [6:0] s, input string nm);
        int n;
        n = 0;
        while (bus.an !== a && n < 40) begin
            tick();
            n++;
        end
        if (bus.an !== a) begin
            total++;
            bad++;
            $display("FAIL %s timeout actual_an=%b required_an=%b", nm, bus.an, a);
        end else begin
            chk(nm, {9'h0, bus.seg}, {9'h0, s});
        end
    endtask

    initial begin
        int hits;
        total      = 0;
        bad        = 0;
        m_cnt      = 0;
        m_val      = 16'h0;
        m_err      = 1'b0;
        m_valid    = 1'b0;
        rst        = 1'b1;
        bus.load   = 1'b0;
        bus.bcd_in = 16'h0;
        bus.blank_lz = 1'b0;

        tick();
        tick();
        chk("reset_an", {12'h0, bus.an}, 16'h000F);
        chk("reset_seg", {9'h0, bus.seg}, 16'h007F);
        chk("reset_err", {15'h0, bus.err}, 16'h0000);
        rst = 1'b0;

        tick();
        chk("first_slot_blank", {12'h0, bus.an}, 16'h000F);
        wait_an(4'b1110, 7'b1000000, "idle_d0");
        wait_an(4'b1101, 7'b1000000, "idle_d1");
        wait_an(4'b1011, 7'b1000000, "idle_d2");
        wait_an(4'b0111, 7'b1000000, "idle_d3");

        do_load(16'h1234);
        wait_an(4'b1110, 7'b0011001, "v1234_d0");
        wait_an(4'b1101, 7'b0110000, "v1234_d1");
        wait_an(4'b1011, 7'b0100100, "v1234_d2");
        wait_an(4'b0111, 7'b1111001, "v1234_d3");

        bus.blank_lz = 1'b1;
        do_load(16'h0070);
        tick();
        hits = 0;
        for (int i = 0; i < 32; i++) begin
            tick();
            if (bus.an == 4'b1011 || bus.an == 4'b0111) hits++;
        end
        chk("lz_upper_never_on", 16'(hits), 16'h0);
        wait_an(4'b1101, 7'b1111000, "lz_d1");
        wait_an(4'b1110, 7'b1000000, "lz_d0");
        do_load(16'h0000);
        tick();
        hits = 0;
        for (int i = 0; i < 32; i++) begin
            tick();
            if (bus.an != 4'b1111 && bus.an != 4'b1110) hits++;
        end
        chk("lz_zero_only_d0", 16'(hits), 16'h0);
        wait_an(4'b1110, 7'b1000000, "lz_zero_d0");
        bus.blank_lz = 1'b0;

        do_load(16'h12A4);
        chk("err_set", {15'h0, bus.err}, 16'h0001);
        wait_an(4'b1101, 7'b0111111, "dash_d1");
        do_load(16'h0005);
        chk("err_clr", {15'h0, bus.err}, 16'h0000);

        do_load(16'h9876);
        wait_an(4'b1011, 7'b0000000, "v9876_d2");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_an", {12'h0, bus.an}, 16'h000F);
        chk("midrst_seg", {9'h0, bus.seg}, 16'h007F);
        chk("midrst_err", {15'h0, bus.err}, 16'h0000);
        tick();
        chk("midrst_blank", {12'h0, bus.an}, 16'h000F);
        tick();
        chk("midrst_d0_first", {12'h0, bus.an}, 16'h000E);
        wait_an(4'b1101, 7'b1000000, "midrst_d1");
        wait_an(4'b1011, 7'b1000000, "midrst_d2");
        wait_an(4'b0111, 7'b1000000, "midrst_d3");

        while ((m_cnt % SD) != SD - 1) tick();
        do_load(16'h4321);
        for (int i = 0; i < 20; i++) tick();
        wait_an(4'b1110, 7'b1111001, "wrap_load_d0");
        wait_an(4'b0111, 7'b0011001, "wrap_load_d3");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bcd_display_scan.md
BCD_DISPLAY_SCAN -- requirements
Module: bcd_display_scan

Interface
REQ-001 Parameter SCAN_DIV, default 50000: clock cycles per digit slot; legal range >=2.
REQ-002 Parameter BLANK_CYC, default 500: cycles at the start of each slot with all anodes off (anti-ghosting); legal range 0..SCAN_DIV-1.
REQ-003 Reset is synchronous and active-high; the block has one clock.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 load  input  1  single-cycle strobe; capture bcd_in on this edge.
REQ-007 bcd_in  input  16  four BCD digits {d3,d2,d1,d0}, d0 in [3:0]; sourced from the cascaded decade counter cnt outputs.
REQ-008 blank_lz  input  1  1 = suppress leading zeros.
REQ-009 an  output  4  digit enables, active-low, an[i] drives digit i.
REQ-010 seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-011 err  output  1  latched value contains a nibble >9.

Function
REQ-012 Hold register val[15:0] SHALL load bcd_in on every edge with load=1; it is otherwise unchanged.
REQ-013 err SHALL be registered and update on the same edge as val: 1 if any bcd_in nibble exceeds 9, else 0.
REQ-014 Prescaler pcnt SHALL count 0..SCAN_DIV-1 and wrap to 0; digit index dig SHALL increment 0->1->2->3->0 on each pcnt wrap.
REQ-015 load SHALL NOT disturb pcnt or dig.
REQ-016 an and seg SHALL be registered, computed from the current pcnt, dig and val, and updated every cycle.
REQ-017 Blank slot: while pcnt<BLANK_CYC, an=4'b1111 and seg=7'b1111111.
REQ-018 Active slot: pcnt>=BLANK_CYC drives an[dig]=0 and all other an bits to 1, unless the digit is blanked (REQ-021).
REQ-019 Decode, val nibble to seg: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-020 A nibble >9 SHALL display a dash, 1111111 with g low (seg=7'b0111111).
REQ-021 With blank_lz=1, digit i (i=3,2,1) is blanked if nibble i and all higher nibbles are 0; a blanked digit SHALL keep an=1111 and seg=1111111 for its slot; digit 0 is never blanked.
REQ-022 Latency: a value captured at edge E SHALL be reflected on seg no later than edge E+1 when its digit is active.
REQ-023 Outputs SHALL be glitch-free: at most one an bit is low in any cycle.

Reset
REQ-024 While rst=1 at an edge: val=0, err=0, pcnt=0, dig=0, an=4'b1111, seg=7'b1111111.
REQ-025 rst SHALL take priority over load; a load coincident with rst is discarded.
REQ-026 After rst deasserts, scanning restarts at digit 0 with pcnt=0, so the first slot begins with its blank interval.

Verification (SCAN_DIV=4, BLANK_CYC=1; 16-cycle frame)
REQ-027 rst=1 for 2 cycles, then 0, with no load -> an=1111/seg=1111111 during reset. Afterwards, per 4-cycle slot, 1 cycle of an=1111 then 3 cycles of an=1110,1101,1011,0111 in turn. seg=1000000 on every active digit. err=0.
REQ-028 load bcd_in=16'h1234, blank_lz=0 -> an=1110 shows seg=0011001; an=1101 shows 0110000; an=1011 shows 0100100; an=0111 shows 1111001. err=0.
REQ-029 blank_lz=1, load 16'h0070 -> digits 3 and 2 keep an=1111 for their slots. an=1011 is never asserted and an=0111 is never asserted. an=1101 shows 1111000 and an=1110 shows 1000000. Then load 16'h0000 -> only digit 0 lights, with seg=1000000.
REQ-030 load 16'h12A4 -> err=1 on the next cycle; an=1101 shows 0111111. Then load 16'h0005 -> err=0.
REQ-031 With val=16'h9876, assert rst for 1 cycle while dig=2 mid-slot -> next cycle an=1111, seg=1111111, err=0. Scanning then resumes from digit 0, showing seg=1000000 on all digits.
REQ-032 Assert load on the same edge as a pcnt wrap -> dig advances normally. The new digit slot displays the new value with no cycle of stale data and no two an bits low simultaneously.
